// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: turns one valid/ready command (single or burst, read or write)
// into pipelined address/data phases, honouring HREADY wait states and two-cycle ERROR.
module ahb_lite_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [2:0]        cmd_burst,
  input  logic [DATA_W-1:0] wdata,
  output logic              wdata_pop,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [2:0] BURST_WRAP4 = 3'b010;
  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_ERR} state_t;

  function automatic logic [ADDR_W-1:0] size_mask(input logic [2:0] size);
    size_mask = (ONE << size) - ONE;
  endfunction

  function automatic logic [3:0] burst_beats(input logic [2:0] burst);
    case (burst)
      3'b010, 3'b011: burst_beats = 4'd4;
      3'b101:         burst_beats = 4'd8;
      default:        burst_beats = 4'd1;
    endcase
  endfunction

  // WRAP4 keeps the upper bits of the (4<<size)-aligned block and wraps the offset.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic [2:0] size,
                                                  input logic [2:0] burst);
    logic [ADDR_W-1:0] sum;
    logic [ADDR_W-1:0] wmask;
    sum   = addr + (ONE << size);
    wmask = (ONE << ({1'b0, size} + 4'd2)) - ONE;
    if (burst == BURST_WRAP4) begin
      next_addr = (addr & ~wmask) | (sum & wmask);
    end else begin
      next_addr = sum;
    end
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic [1:0]        htrans_q, htrans_d;
  logic              hwrite_q, hwrite_d;
  logic [2:0]        hsize_q, hsize_d;
  logic [2:0]        hburst_q, hburst_d;
  logic [DATA_W-1:0] hwdata_q, hwdata_d;
  logic [3:0]        beats_left_q, beats_left_d;
  logic              dp_q, dp_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  // Next-state and output decode; dp_q marks a data phase currently on the bus.
  always_comb begin
    state_d       = state_q;
    haddr_d       = haddr_q;
    htrans_d      = htrans_q;
    hwrite_d      = hwrite_q;
    hsize_d       = hsize_q;
    hburst_d      = hburst_q;
    hwdata_d      = hwdata_q;
    beats_left_d  = beats_left_q;
    dp_d          = dp_q;
    cmd_ready_d   = cmd_ready_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    done_d        = 1'b0;
    err_d         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d      = S_ADDR;
          cmd_ready_d  = 1'b0;
          haddr_d      = cmd_addr & ~size_mask(cmd_size);
          htrans_d     = TR_NONSEQ;
          hwrite_d     = cmd_write;
          hsize_d      = cmd_size;
          hburst_d     = cmd_burst;
          beats_left_d = burst_beats(cmd_burst) - 4'd1;
          dp_d         = 1'b0;
        end else begin
          cmd_ready_d = 1'b1;
        end
      end
      S_ADDR: begin
        if (dp_q && HRESP && !HREADY) begin
          state_d  = S_ERR;
          htrans_d = TR_IDLE;
        end else if (HREADY) begin
          if (dp_q && !hwrite_q && !HRESP) begin
            rdata_d       = HRDATA;
            rdata_valid_d = 1'b1;
          end else begin
            rdata_valid_d = 1'b0;
          end
          dp_d = 1'b1;
          if (hwrite_q) begin
            hwdata_d = wdata;
          end else begin
            hwdata_d = hwdata_q;
          end
          if (beats_left_q == 4'd0) begin
            htrans_d = TR_IDLE;
            state_d  = S_DATA;
          end else begin
            htrans_d     = TR_SEQ;
            haddr_d      = next_addr(haddr_q, hsize_q, hburst_q);
            beats_left_d = beats_left_q - 4'd1;
          end
        end else begin
          state_d = S_ADDR;
        end
      end
      S_DATA: begin
        if (HRESP && !HREADY) begin
          state_d = S_ERR;
        end else if (HREADY) begin
          if (!hwrite_q && !HRESP) begin
            rdata_d       = HRDATA;
            rdata_valid_d = 1'b1;
          end else begin
            rdata_valid_d = 1'b0;
          end
          done_d      = 1'b1;
          cmd_ready_d = 1'b1;
          dp_d        = 1'b0;
          state_d     = S_IDLE;
        end else begin
          state_d = S_DATA;
        end
      end
      S_ERR: begin
        if (HREADY) begin
          done_d      = 1'b1;
          err_d       = 1'b1;
          cmd_ready_d = 1'b1;
          dp_d        = 1'b0;
          state_d     = S_IDLE;
        end else begin
          state_d = S_ERR;
        end
      end
      default: begin
        state_d  = S_IDLE;
        htrans_d = TR_IDLE;
        dp_d     = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q       <= S_IDLE;
      haddr_q       <= {ADDR_W{1'b0}};
      htrans_q      <= TR_IDLE;
      hwrite_q      <= 1'b0;
      hsize_q       <= 3'b000;
      hburst_q      <= 3'b000;
      hwdata_q      <= {DATA_W{1'b0}};
      beats_left_q  <= 4'd0;
      dp_q          <= 1'b0;
      cmd_ready_q   <= 1'b1;
      rdata_q       <= {DATA_W{1'b0}};
      rdata_valid_q <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      haddr_q       <= haddr_d;
      htrans_q      <= htrans_d;
      hwrite_q      <= hwrite_d;
      hsize_q       <= hsize_d;
      hburst_q      <= hburst_d;
      hwdata_q      <= hwdata_d;
      beats_left_q  <= beats_left_d;
      dp_q          <= dp_d;
      cmd_ready_q   <= cmd_ready_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign wdata_pop   = (state_q == S_ADDR) && HREADY && hwrite_q;
  assign cmd_ready   = cmd_ready_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign done        = done_q;
  assign err         = err_q;
  assign HADDR       = haddr_q;
  assign HTRANS      = htrans_q;
  assign HWRITE      = hwrite_q;
  assign HSIZE       = hsize_q;
  assign HBURST      = hburst_q;
  assign HPROT       = 4'b0011;
  assign HWDATA      = hwdata_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Self-checking bench for ahb_lite_master: acts as the AHB slave, records completed
// address phases, write data, read data and done/err, and compares them to scoreboards.
module tb_ahb_lite_master;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size, cmd_burst;
  logic [31:0] wdata, rdata, HADDR, HWDATA, HRDATA;
  logic        wdata_pop, rdata_valid, done, err, HWRITE, HREADY, HRESP;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  always #5 HCLK = ~HCLK;

  ahb_lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .wdata(wdata), .wdata_pop(wdata_pop), .rdata(rdata), .rdata_valid(rdata_valid),
    .done(done), .err(err), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
    .HRESP(HRESP)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
  } aph_t;

  aph_t        exp_aph[$], obs_aph[$];
  logic [31:0] exp_rd[$], obs_rd[$], exp_wd[$], obs_wd[$];
  logic        obs_done[$];
  int          obs_pops, done_cyc;
  logic [31:0] cyc_haddr[64];
  logic [1:0]  cyc_htrans[64];
  logic        dph_valid, dph_write;
  logic [31:0] dph_addr, wbase;
  int          widx;
  logic [63:0] stall_mask, resp_mask;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [31:0] slave_data(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic aph_t mk(input logic [31:0] a, input logic [1:0] t, input logic w,
                              input logic [2:0] s, input logic [2:0] b);
    mk.addr = a; mk.trans = t; mk.write = w; mk.size = s; mk.burst = b;
  endfunction

  task automatic clear_sb();
    exp_aph.delete(); obs_aph.delete(); exp_rd.delete(); obs_rd.delete();
    exp_wd.delete(); obs_wd.delete(); obs_done.delete();
    obs_pops = 0; done_cyc = -1; stall_mask = 64'd0; resp_mask = 64'd0;
  endtask

  // One bus cycle as the slave: drive response at negedge, record, then sample pulses.
  task automatic tick(input int i);
    logic pop_now;
    @(negedge HCLK);
    HREADY = !stall_mask[i];
    HRESP  = resp_mask[i];
    HRDATA = dph_valid ? slave_data(dph_addr) : 32'h0;
    #1;
    cyc_haddr[i]  = HADDR;
    cyc_htrans[i] = HTRANS;
    if (HTRANS != 2'b00 && HREADY) obs_aph.push_back(mk(HADDR, HTRANS, HWRITE, HSIZE, HBURST));
    pop_now = wdata_pop;
    if (pop_now) obs_pops++;
    if (dph_valid && dph_write && HREADY && !HRESP) obs_wd.push_back(HWDATA);
    if (dph_valid && HRESP && !HREADY) dph_valid = 1'b0;
    else if (HREADY) begin
      dph_valid = (HTRANS != 2'b00);
      dph_addr  = HADDR;
      dph_write = HWRITE;
    end
    @(posedge HCLK);
    #1;
    if (pop_now) begin widx++; wdata = wbase + widx; end
    if (rdata_valid) obs_rd.push_back(rdata);
    if (done) begin obs_done.push_back(err); done_cyc = i; end
  endtask

  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [2:0] s,
                          input logic [2:0] b);
    @(negedge HCLK);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_size = s; cmd_burst = b;
    HREADY = 1'b1; HRESP = 1'b0;
    widx = 0; wdata = wbase;
    @(posedge HCLK);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input int budget);
    for (int i = 0; i < budget; i++) begin
      tick(i);
      if (obs_done.size() > 0) break;
    end
  endtask

  task automatic test_reset();
    HRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0;
    cmd_size = 3'd0; cmd_burst = 3'd0; wdata = 32'h0; HRDATA = 32'h0;
    HREADY = 1'b1; HRESP = 1'b0; dph_valid = 1'b0; dph_write = 1'b0; dph_addr = 32'h0;
    wbase = 32'h0; widx = 0;
    repeat (3) @(posedge HCLK);
    #1;
    vectors++;
    if ({HTRANS, HADDR, HWRITE, HSIZE, HBURST, HWDATA} !== {2'b00, 32'h0, 1'b0, 3'd0, 3'd0, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_ahb got htrans=%0h haddr=%h hwdata=%h expected all zero", HTRANS, HADDR, HWDATA);
    end
    vectors++;
    if ({HPROT, cmd_ready, rdata, rdata_valid, done, err} !== {4'b0011, 1'b1, 32'h0, 3'b000}) begin
      miscompares++;
      $display("FAIL reset_misc got hprot=%b rdy=%b rdata=%h rv=%b done=%b err=%b expected 0011 1 0 0 0 0",
               HPROT, cmd_ready, rdata, rdata_valid, done, err);
    end
    @(negedge HCLK);
    HRESETn = 1'b1;
  endtask

  task automatic test_single_write();
    clear_sb();
    wbase = 32'hDEADBEEF;
    exp_aph.push_back(mk(32'h100, 2'b10, 1'b1, 3'd2, 3'b000));
    exp_wd.push_back(32'hDEADBEEF);
    send_cmd(1'b1, 32'h100, 3'd2, 3'b000);
    vectors++;
    if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL t1_busy cmd_ready got %b expected 0", cmd_ready); end
    run_cmd(20);
    vectors++;
    if (cyc_htrans[0] !== 2'b10 || cyc_haddr[0] !== 32'h100) begin
      miscompares++; $display("FAIL t1_nonseq got %0h/%h expected 2/00000100", cyc_htrans[0], cyc_haddr[0]);
    end
    vectors++;
    if (cyc_htrans[1] !== 2'b00) begin miscompares++; $display("FAIL t1_idle got %0h expected 0", cyc_htrans[1]); end
    vectors++;
    if (done_cyc !== 1) begin miscompares++; $display("FAIL t1_done_cycle got %0d expected 1", done_cyc); end
    vectors++;
    if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL t1_ready_back got %b expected 1", cmd_ready); end
    vectors++;
    if (obs_pops !== 1) begin miscompares++; $display("FAIL t1_pops got %0d expected 1", obs_pops); end
    vectors++;
    if (obs_aph.size() != exp_aph.size()) begin miscompares++; $display("FAIL t1_aph_count got %0d expected %0d", obs_aph.size(), exp_aph.size()); end
    while (exp_aph.size() > 0 && obs_aph.size() > 0) begin
      aph_t e, o; e = exp_aph.pop_front(); o = obs_aph.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL t1_aph got %h expected %h", o, e); end
    end
    vectors++;
    if (obs_wd.size() != exp_wd.size()) begin miscompares++; $display("FAIL t1_wd_count got %0d expected %0d", obs_wd.size(), exp_wd.size()); end
    while (exp_wd.size() > 0 && obs_wd.size() > 0) begin
      logic [31:0] e, o; e = exp_wd.pop_front(); o = obs_wd.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL t1_hwdata got %h expected %h", o, e); end
    end
    vectors++;
    if (obs_done.size() != 1 || obs_done[0] !== 1'b0) begin miscompares++; $display("FAIL t1_done got count %0d expected one done with err=0", obs_done.size()); end
  endtask

  task automatic test_incr4_read_wait();
    clear_sb();
    stall_mask = 64'b110;
    exp_aph.push_back(mk(32'h20, 2'b10, 1'b0, 3'd2, 3'b011));
    exp_aph.push_back(mk(32'h24, 2'b11, 1'b0, 3'd2, 3'b011));
    exp_aph.push_back(mk(32'h28, 2'b11, 1'b0, 3'd2, 3'b011));
    exp_aph.push_back(mk(32'h2C, 2'b11, 1'b0, 3'd2, 3'b011));
    foreach (exp_aph[k]) exp_rd.push_back(slave_data(exp_aph[k].addr));
    send_cmd(1'b0, 32'h20, 3'd2, 3'b011);
    run_cmd(30);
    for (int c = 1; c <= 3; c++) begin
      vectors++;
      if (cyc_haddr[c] !== 32'h24 || cyc_htrans[c] !== 2'b11) begin
        miscompares++; $display("FAIL t2_hold cycle %0d got %h/%0h expected 00000024/3", c, cyc_haddr[c], cyc_htrans[c]);
      end
    end
    vectors++;
    if (obs_aph.size() != exp_aph.size()) begin miscompares++; $display("FAIL t2_aph_count got %0d expected %0d", obs_aph.size(), exp_aph.size()); end
    while (exp_aph.size() > 0 && obs_aph.size() > 0) begin
      aph_t e, o; e = exp_aph.pop_front(); o = obs_aph.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL t2_aph got %h expected %h", o, e); end
    end
    vectors++;
    if (obs_rd.size() != exp_rd.size()) begin miscompares++; $display("FAIL t2_rd_count got %0d expected %0d", obs_rd.size(), exp_rd.size()); end
    while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
      logic [31:0] e, o; e = exp_rd.pop_front(); o = obs_rd.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL t2_rdata got %h expected %h", o, e); end
    end
    vectors++;
    if (obs_done.size() != 1 || obs_done[0] !== 1'b0) begin miscompares++; $display("FAIL t2_done got count %0d expected one done with err=0", obs_done.size()); end
  endtask

  task automatic test_wrap4_read();
    clear_sb();
    exp_aph.push_back(mk(32'h38, 2'b10, 1'b0, 3'd2, 3'b010));
    exp_aph.push_back(mk(32'h3C, 2'b11, 1'b0, 3'd2, 3'b010));
    exp_aph.push_back(mk(32'h30, 2'b11, 1'b0, 3'd2, 3'b010));
    exp_aph.push_back(mk(32'h34, 2'b11, 1'b0, 3'd2, 3'b010));
    foreach (exp_aph[k]) exp_rd.push_back(slave_data(exp_aph[k].addr));
    send_cmd(1'b0, 32'h38, 3'd2, 3'b010);
    run_cmd(30);
    vectors++;
    if (obs_aph.size() != exp_aph.size()) begin miscompares++; $display("FAIL t3_aph_count got %0d expected %0d", obs_aph.size(), exp_aph.size()); end
    while (exp_aph.size() > 0 && obs_aph.size() > 0) begin
      aph_t e, o; e = exp_aph.pop_front(); o = obs_aph.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL t3_aph got %h expected %h", o, e); end
    end
    vectors++;
    if (obs_rd.size() != exp_rd.size()) begin miscompares++; $display("FAIL t3_rd_count got %0d expected %0d", obs_rd.size(), exp_rd.size()); end
    while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
      logic [31:0] e, o; e = exp_rd.pop_front(); o = obs_rd.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL t3_rdata got %h expected %h", o, e); end
    end
  endtask

  task automatic test_incr4_half_write();
    clear_sb();
    wbase = 32'h1111_0000;
    exp_aph.push_back(mk(32'h102, 2'b10, 1'b1, 3'd1, 3'b011));
    exp_aph.push_back(mk(32'h104, 2'b11, 1'b1, 3'd1, 3'b011));
    exp_aph.push_back(mk(32'h106, 2'b11, 1'b1, 3'd1, 3'b011));
    exp_aph.push_back(mk(32'h108, 2'b11, 1'b1, 3'd1, 3'b011));
    for (int k = 0; k < 4; k++) exp_wd.push_back(32'h1111_0000 + k);
    send_cmd(1'b1, 32'h102, 3'd1, 3'b011);
    run_cmd(30);
    vectors++;
    if (obs_pops !== 4) begin miscompares++; $display("FAIL t4_pops got %0d expected 4", obs_pops); end
    vectors++;
    if (obs_aph.size() != exp_aph.size()) begin miscompares++; $display("FAIL t4_aph_count got %0d expected %0d", obs_aph.size(), exp_aph.size()); end
    while (exp_aph.size() > 0 && obs_aph.size() > 0) begin
      aph_t e, o; e = exp_aph.pop_front(); o = obs_aph.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL t4_aph got %h expected %h", o, e); end
    end
    vectors++;
    if (obs_wd.size() != exp_wd.size()) begin miscompares++; $display("FAIL t4_wd_count got %0d expected %0d", obs_wd.size(), exp_wd.size()); end
    while (exp_wd.size() > 0 && obs_wd.size() > 0) begin
      logic [31:0] e, o; e = exp_wd.pop_front(); o = obs_wd.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL t4_hwdata got %h expected %h", o, e); end
    end
  endtask

  task automatic test_error_incr8();
    clear_sb();
    wbase = 32'hA000_0000;
    stall_mask = 64'b01000;
    resp_mask  = 64'b11000;
    exp_aph.push_back(mk(32'h200, 2'b10, 1'b1, 3'd2, 3'b101));
    exp_aph.push_back(mk(32'h204, 2'b11, 1'b1, 3'd2, 3'b101));
    exp_aph.push_back(mk(32'h208, 2'b11, 1'b1, 3'd2, 3'b101));
    exp_wd.push_back(32'hA000_0000);
    exp_wd.push_back(32'hA000_0001);
    send_cmd(1'b1, 32'h200, 3'd2, 3'b101);
    run_cmd(30);
    vectors++;
    if (cyc_htrans[4] !== 2'b00) begin miscompares++; $display("FAIL t5_cancel htrans got %0h expected 0", cyc_htrans[4]); end
    vectors++;
    if (obs_done.size() != 1 || obs_done[0] !== 1'b1) begin miscompares++; $display("FAIL t5_err got count %0d expected one done with err=1", obs_done.size()); end
    vectors++;
    if (done_cyc !== 4) begin miscompares++; $display("FAIL t5_done_cycle got %0d expected 4", done_cyc); end
    vectors++;
    if (obs_pops !== 3) begin miscompares++; $display("FAIL t5_pops got %0d expected 3", obs_pops); end
    vectors++;
    if (obs_aph.size() != exp_aph.size()) begin miscompares++; $display("FAIL t5_aph_count got %0d expected %0d", obs_aph.size(), exp_aph.size()); end
    while (exp_aph.size() > 0 && obs_aph.size() > 0) begin
      aph_t e, o; e = exp_aph.pop_front(); o = obs_aph.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL t5_aph got %h expected %h", o, e); end
    end
    vectors++;
    if (obs_wd.size() != exp_wd.size()) begin miscompares++; $display("FAIL t5_wd_count got %0d expected %0d", obs_wd.size(), exp_wd.size()); end
    while (exp_wd.size() > 0 && obs_wd.size() > 0) begin
      logic [31:0] e, o; e = exp_wd.pop_front(); o = obs_wd.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL t5_hwdata got %h expected %h", o, e); end
    end
  endtask

  task automatic test_reset_mid_burst();
    clear_sb();
    send_cmd(1'b0, 32'h300, 3'd2, 3'b011);
    tick(0);
    tick(1);
    @(negedge HCLK);
    HRESETn = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
    @(posedge HCLK);
    #1;
    vectors++;
    if (HTRANS !== 2'b00 || cmd_ready !== 1'b1 || done !== 1'b0) begin
      miscompares++; $display("FAIL t6_reset got htrans=%0h rdy=%b done=%b expected 0 1 0", HTRANS, cmd_ready, done);
    end
    @(negedge HCLK);
    HRESETn = 1'b1;
    dph_valid = 1'b0;
    clear_sb();
    for (int i = 0; i < 4; i++) tick(i);
    vectors++;
    if (obs_done.size() != 0 || obs_aph.size() != 0) begin
      miscompares++; $display("FAIL t6_quiet got done=%0d aph=%0d expected 0 0", obs_done.size(), obs_aph.size());
    end
    clear_sb();
    exp_aph.push_back(mk(32'h400, 2'b10, 1'b0, 3'd2, 3'b000));
    exp_rd.push_back(slave_data(32'h400));
    send_cmd(1'b0, 32'h400, 3'd2, 3'b000);
    run_cmd(20);
    vectors++;
    if (obs_aph.size() != 1 || obs_aph[0] !== exp_aph[0]) begin miscompares++; $display("FAIL t6_fresh_aph got count %0d expected 1 matching %h", obs_aph.size(), exp_aph[0]); end
    vectors++;
    if (obs_rd.size() != 1 || obs_rd[0] !== exp_rd[0]) begin miscompares++; $display("FAIL t6_fresh_rdata got count %0d expected 1 of %h", obs_rd.size(), exp_rd[0]); end
    vectors++;
    if (obs_done.size() != 1 || obs_done[0] !== 1'b0) begin miscompares++; $display("FAIL t6_fresh_done got count %0d expected one done with err=0", obs_done.size()); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_incr4_read_wait();
    test_wrap4_read();
    test_incr4_half_write();
    test_error_incr8();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
